// File: rtl/core_pkg.sv
// Shared definitions for the 3-stage core: next-PC select codes, branch
// comparator codes, reset PC, canonical NOP and the redirect FSM states.
package core_pkg;

    localparam logic [1:0] PC_4   = 2'b00;
    localparam logic [1:0] PC_ALU = 2'b01;
    localparam logic [1:0] PC_C   = 2'b10;
    localparam logic [1:0] PC_EPC = 2'b11;

    localparam logic [2:0] BR_IS_NONE = 3'b000;
    localparam logic [2:0] BR_IS_LTU  = 3'b001;
    localparam logic [2:0] BR_IS_LT   = 3'b010;
    localparam logic [2:0] BR_IS_EQ   = 3'b011;
    localparam logic [2:0] BR_IS_GEU  = 3'b100;
    localparam logic [2:0] BR_IS_GE   = 3'b101;
    localparam logic [2:0] BR_IS_NEQ  = 3'b110;

    localparam logic [31:0] START_PC = 32'h0000_1000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    // RUN: no stale fetches pending; DRAIN: stale responses still to be killed
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } redirect_state_t;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Fetch-port bundle between the redirect controller (master) and the
// instruction fetch unit (slave).
interface branch_redirect_ctrl_if;
    logic        fe_req_valid;
    logic [31:0] fe_req_pc;
    logic        fe_req_ready;
    logic        fe_resp_valid;
    logic        fe_resp_kill;

    modport master (
        output fe_req_valid,
        output fe_req_pc,
        output fe_resp_kill,
        input  fe_req_ready,
        input  fe_resp_valid
    );

    modport slave (
        input  fe_req_valid,
        input  fe_req_pc,
        input  fe_resp_kill,
        output fe_req_ready,
        output fe_resp_valid
    );
endinterface

// File: rtl/branch.sv
// Branch condition comparator: evaluates rs1 against rs2 for the selected
// branch type; a type of none never reports taken.
module branch
    import core_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  br_type,
    output logic        taken
);

    // Signed and unsigned compares selected by branch type
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_IS_LTU: taken = (rs1 < rs2);
            BR_IS_LT:  taken = ($signed(rs1) < $signed(rs2));
            BR_IS_EQ:  taken = (rs1 == rs2);
            BR_IS_GEU: taken = (rs1 >= rs2);
            BR_IS_GE:  taken = ($signed(rs1) >= $signed(rs2));
            BR_IS_NEQ: taken = (rs1 != rs2);
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Next-PC / redirect controller: owns the fetch PC, decides redirects from
// the EX stage, tracks in-flight fetches and kills stale responses.
// Optional macro BRANCH_PERF_EN builds the branch / taken perf counters;
// without it both counter ports are tied to zero.
module branch_redirect_ctrl #(
    parameter logic [31:0] START_PC        = core_pkg::START_PC,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          CNT_W           = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic [31:0]            ex_pc,
    input  logic [1:0]             ex_pc_sel,
    input  logic [2:0]             ex_br_type,
    input  logic [31:0]            ex_rs1,
    input  logic [31:0]            ex_rs2,
    input  logic [31:0]            ex_alu_out,
    input  logic [31:0]            epc,
    branch_redirect_ctrl_if.master fe,
    output logic                   flush,
    output logic                   redirect,
    output logic                   br_taken,
    output logic [31:0]            perf_br_cnt,
    output logic [31:0]            perf_taken_cnt
);
    import core_pkg::*;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]      pc_reg;
    logic [31:0]      pc_next;
    logic [31:0]      target;
    logic [CNT_W-1:0] out_cnt_reg;
    logic [CNT_W-1:0] out_cnt_next;
    logic [CNT_W-1:0] drop_cnt_reg;
    logic [CNT_W-1:0] drop_cnt_next;
    redirect_state_t  state_reg;
    redirect_state_t  state_next;
    logic             squash_reg;
    logic             cmp_taken;
    logic             ex_live;
    logic             req_fire;
    logic             resp_fire;

    branch u_branch (
        .rs1     (ex_rs1),
        .rs2     (ex_rs2),
        .br_type (ex_br_type),
        .taken   (cmp_taken)
    );

    // An EX instruction right after a redirect is younger than the redirecting one
    assign ex_live  = rst_n & ex_valid & ~squash_reg;
    assign br_taken = ex_live & cmp_taken;
    assign redirect = ex_live & ((ex_pc_sel != PC_4) | cmp_taken);
    assign flush    = redirect;

    // Redirect target; jalr-style targets drop bit 0
    always_comb begin
        target = ex_alu_out;
        case (ex_pc_sel)
            PC_ALU:  target = {ex_alu_out[31:1], 1'b0};
            PC_C:    target = ex_pc + 32'd4;
            PC_EPC:  target = epc;
            default: target = ex_alu_out;
        endcase
    end

    // A returning response frees a slot in the same cycle
    assign fe.fe_req_valid = rst_n & ((out_cnt_reg < MAX_CNT) | fe.fe_resp_valid) & ~redirect;
    assign fe.fe_req_pc    = pc_reg;
    assign req_fire        = fe.fe_req_valid & fe.fe_req_ready;
    assign resp_fire       = rst_n & fe.fe_resp_valid;
    assign fe.fe_resp_kill = resp_fire & (flush | (state_reg == DRAIN));

    // In-flight counter; a stray response with nothing outstanding cannot underflow it
    always_comb begin
        out_cnt_next = out_cnt_reg;
        if (req_fire && !resp_fire) begin
            out_cnt_next = out_cnt_reg + 1'b1;
        end else if (!req_fire && resp_fire && (out_cnt_reg != '0)) begin
            out_cnt_next = out_cnt_reg - 1'b1;
        end
    end

    // Drop counter: redirect captures every older fetch still in flight
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (redirect) begin
            drop_cnt_next = out_cnt_next;
        end else if (resp_fire && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - 1'b1;
        end
        state_next = (drop_cnt_next != '0) ? DRAIN : RUN;
    end

    // Fetch PC: redirect target wins, otherwise advance on an accepted request
    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = target;
        end else if (req_fire) begin
            pc_next = pc_reg + 32'd4;
        end
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg       <= START_PC;
            out_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            state_reg    <= RUN;
            squash_reg   <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            out_cnt_reg  <= out_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
            state_reg    <= state_next;
            squash_reg   <= redirect;
        end
    end

`ifdef BRANCH_PERF_EN
    logic [31:0] perf_br_reg;
    logic [31:0] perf_taken_reg;

    // Count non-squashed conditional branches and how many were taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_br_reg    <= '0;
            perf_taken_reg <= '0;
        end else begin
            if (ex_live && (ex_br_type != BR_IS_NONE)) begin
                perf_br_reg <= perf_br_reg + 32'd1;
            end
            if (br_taken) begin
                perf_taken_reg <= perf_taken_reg + 32'd1;
            end
        end
    end

    assign perf_br_cnt    = rst_n ? perf_br_reg    : 32'd0;
    assign perf_taken_cnt = rst_n ? perf_taken_reg : 32'd0;
`else
    assign perf_br_cnt    = 32'd0;
    assign perf_taken_cnt = 32'd0;
`endif

endmodule
